// File: rtl/seq_det_pkg.sv
// Shared types and constants for the scheduled 1101 sequence detector.
// Optional feature macro: SEQ_DET_CARRY_EN (detector state survives job boundaries).
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } det_t;

    localparam logic [3:0] PATTERN = 4'b1101;

endpackage

// File: rtl/seq_det_1101.sv
// Overlapping Mealy detector for the bit pattern 1101.
// clr forces the start state; the state only advances when en is high.
module seq_det_1101 (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic in,
    output logic match
);
    import seq_det_pkg::*;

    det_t st;
    det_t st_nx;

    // Detector state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) st <= S0;
        else       st <= st_nx;
    end

    // Next-state and Mealy match output
    always_comb begin
        st_nx = st;
        match = 1'b0;
        if (clr) begin
            st_nx = S0;
        end else if (en) begin
            unique case (st)
                S0: st_nx = in ? S1 : S0;
                S1: st_nx = in ? S2 : S0;
                S2: st_nx = in ? S2 : S3;
                S3: begin
                    st_nx = in ? S1 : S0;
                    match = in;
                end
            endcase
        end
    end

endmodule

// File: rtl/seq_det_sched.sv
// Two-requester round-robin scheduler that serializes words MSB first
// into a 1101 detector. Macro SEQ_DET_CARRY_EN keeps detector state across jobs.
module seq_det_sched #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              busy,
    output logic              ser_bit,
    output logic              done,
    output logic              done_id,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [3:0]        window
);
    import seq_det_pkg::*;

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    fsm_t              state;
    fsm_t              state_nx;
    logic              last;
    logic              accept;
    logic              det_en;
    logic              det_clr;
    logic              match;
    logic [DATA_W-1:0] word;
    logic [IDX_W-1:0]  idx;

    // Job FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Arbitration, next state and per-state outputs
    always_comb begin
        state_nx   = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        ser_bit    = 1'b0;
        unique case (state)
            IDLE: begin
                // last=1 means requester 1 was served most recently
                req0_ready = req0_valid && (!req1_valid || last);
                req1_ready = req1_valid && (!req0_valid || !last);
                if (req0_valid || req1_valid) state_nx = SHIFT;
            end
            SHIFT: begin
                busy    = 1'b1;
                ser_bit = word[idx];
                if (idx == '0) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign accept = req0_ready | req1_ready;
    assign det_en = (state == SHIFT);

`ifdef SEQ_DET_CARRY_EN
    assign det_clr = 1'b0;
`else
    assign det_clr = accept;
`endif

    // Job capture, bit index, window shift and saturating match count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word      <= '0;
            idx       <= '0;
            last      <= 1'b1;
            done_id   <= 1'b0;
            match_cnt <= '0;
            window    <= '0;
        end else if (accept) begin
            word      <= req1_ready ? req1_data : req0_data;
            done_id   <= req1_ready;
            last      <= req1_ready;
            match_cnt <= '0;
            idx       <= IDX_W'(DATA_W - 1);
        end else if (det_en) begin
            window <= {ser_bit, window[3:1]};
            idx    <= idx - IDX_W'(1);
            if (match && (match_cnt != '1))
                match_cnt <= match_cnt + CNT_W'(1);
        end
    end

    seq_det_1101 u_det (
        .clk   (clk),
        .reset (reset),
        .clr   (det_clr),
        .en    (det_en),
        .in    (ser_bit),
        .match (match)
    );

endmodule

// File: tb/tb_seq_det_sched.sv
// Self-checking bench for seq_det_sched: directed table, corner sequences
// and randomized jobs against a bit-history reference model.
module tb_seq_det_sched;

    localparam int DW = 8;
    localparam int CW = 3;
`ifdef SEQ_DET_CARRY_EN
    localparam bit CARRY = 1'b1;
`else
    localparam bit CARRY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          busy, ser_bit, done, done_id;
    logic [CW-1:0] match_cnt;
    logic [3:0]    window;

    always #5 clk = ~clk;

    seq_det_sched #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .busy       (busy),
        .ser_bit    (ser_bit),
        .done       (done),
        .done_id    (done_id),
        .match_cnt  (match_cnt),
        .window     (window)
    );

    int n_vec = 0;
    int n_err = 0;

    // reference model state: who was served last, bit history since reset
    bit       last_srv;
    int       hlen;
    logic [3:0] hist;

    typedef struct {
        bit            rid;
        logic [DW-1:0] d;
        int            cnt;
        logic [3:0]    win;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_scan(input logic [DW-1:0] d);
        int c = 0;
        if (!CARRY) begin
            hlen = 0;
            hist = '0;
        end
        for (int i = DW - 1; i >= 0; i--) begin
            hist = {hist[2:0], d[i]};
            if (hlen < 4) hlen++;
            if (hlen >= 4 && hist == 4'b1101) c++;
        end
        if (c > (1 << CW) - 1) c = (1 << CW) - 1;
        return c;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("reset_out",
            {busy, done, ser_bit, done_id, match_cnt, window,
             req0_ready, req1_ready}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        last_srv = 1'b1;
        hlen = 0;
        hist = '0;
    endtask

    task automatic run_job(input bit v0, input bit v1,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                           input bit imm,
                           output int got_cnt, output logic [3:0] got_win);
        bit            g;
        logic [DW-1:0] d;
        logic [DW-1:0] sb;
        bit            bad;
        int            n;
        int            ecnt;
        g = (v0 && v1) ? ~last_srv : v1;
        d = g ? d1 : d0;
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
        #1;
        n = 0;
        while (!(req0_ready || req1_ready) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (imm) chk("grant_wait", n, 1);
        chk("grant", {req1_ready, req0_ready}, g ? 2 : 1);
        @(posedge clk);
        #1;
        if (g) req1_valid = 1'b0;
        else   req0_valid = 1'b0;
        last_srv = g;
        ecnt = model_scan(d);
        sb  = '0;
        bad = 1'b0;
        n   = 0;
        while (!done && n < 4 * DW) begin
            if (n < DW) sb[DW-1-n] = ser_bit;
            if (req0_ready || req1_ready || !busy) bad = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, DW);
        chk("ser_bits", sb, d);
        chk("shift_ready_busy", bad, 0);
        chk("done_id", done_id, g);
        chk("match_cnt", match_cnt, ecnt);
        chk("window", window, {d[0], d[1], d[2], d[3]});
        got_cnt = match_cnt;
        got_win = window;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int         c;
        logic [3:0] w;
        logic [3:0] w_hold;
        int         nd;
        bit         v0, v1;

        tbl[0] = '{rid: 1'b0, d: 8'b11011011, cnt: 2, win: 4'b1101};
        tbl[1] = '{rid: 1'b1, d: 8'b00000110, cnt: 0, win: 4'b0110};
        tbl[2] = '{rid: 1'b0, d: 8'b10000000, cnt: CARRY ? 1 : 0, win: 4'b0000};
        tbl[3] = '{rid: 1'b1, d: 8'b11111111, cnt: 0, win: 4'b1111};

        req0_data = '0;
        req1_data = '0;
        do_reset();

        for (int i = 0; i < 4; i++) begin
            run_job(!tbl[i].rid, tbl[i].rid, tbl[i].d, tbl[i].d, 1'b0, c, w);
            chk("tbl_cnt", c, tbl[i].cnt);
            chk("tbl_win", w, tbl[i].win);
        end

        // one-cycle done, results hold in IDLE
        w_hold = window;
        @(posedge clk);
        #1;
        chk("done_pulse", {done, busy}, 0);
        chk("hold_win", window, w_hold);
        chk("hold_id", done_id, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_win_late", window, w_hold);

        // simultaneous requests after reset: 0 then 1
        do_reset();
        run_job(1'b1, 1'b1, 8'hD5, 8'h6D, 1'b0, c, w);
        run_job(1'b0, 1'b1, 8'h00, 8'h6D, 1'b1, c, w);

        // requester 1 alone, back-to-back
        run_job(1'b0, 1'b1, 8'h00, 8'hB6, 1'b1, c, w);
        run_job(1'b0, 1'b1, 8'h00, 8'h0D, 1'b1, c, w);
        run_job(1'b0, 1'b1, 8'h00, 8'hFF, 1'b1, c, w);

        // reset in the 4th SHIFT cycle
        @(posedge clk);
        #1;
        req0_valid = 1'b1;
        req0_data  = 8'b11011011;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_busy", busy, 1);
        do_reset();
        nd = 0;
        repeat (2 * DW) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        chk("no_done_after_abort", nd, 0);
        run_job(1'b1, 1'b1, 8'b11011011, 8'h00, 1'b0, c, w);
        chk("post_reset_cnt", c, 2);

        // randomized jobs
        for (int i = 0; i < 40; i++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            run_job(v0, v1, DW'($urandom), DW'($urandom), 1'b0, c, w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_det_sched.md
SEQ_DET_SCHED -- requirements
Module: seq_det_sched

Interface
REQ-001 Parameter DATA_W, default 8: width of each requester word; legal range 4..16.
REQ-002 Parameter CNT_W, default 3: width of the match counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0_valid / req1_valid  input  1  requester i has a word pending.
REQ-006 req0_data / req1_data  input  DATA_W  word to scan, serialized MSB first.
REQ-007 req0_ready / req1_ready  output  1  grant; a word transfers on the edge where valid and ready are both 1.
REQ-008 busy  output  1  high while a job is in the SHIFT or DONE state.
REQ-009 ser_bit  output  1  bit currently fed to the detector; 0 when not in SHIFT.
REQ-010 done  output  1  one-cycle pulse marking job completion.
REQ-011 done_id  output  1  requester that owned the completed job.
REQ-012 match_cnt  output  CNT_W  number of 1101 detections in the completed job.
REQ-013 window  output  4  last four serialized bits, with the newest bit in window[3].

Function
REQ-014 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-015 In IDLE, ready SHALL be combinational and asserted to exactly one valid requester; if neither requester is valid, both ready outputs SHALL be 0.
REQ-016 Arbitration SHALL be round-robin:
- When both requesters are valid, grant goes to the one not served last.
- The last-served pointer resets to requester 1, so requester 0 wins first.
REQ-017 On an accept edge the block SHALL:
- capture the word and the owner id;
- clear match_cnt;
- load bit index DATA_W-1;
- enter SHIFT.
REQ-018 In SHIFT, ser_bit SHALL equal word[bit index]; each edge feeds that bit to the detector, shifts it into window[3] (window[k] <= window[k+1]), and decrements the index.
REQ-019 After the edge that feeds bit 0, the FSM SHALL enter DONE, so done is asserted exactly DATA_W cycles after the accept edge.
REQ-020 DONE SHALL last one cycle with done=1, then return to IDLE; ready SHALL be 0 in SHIFT and DONE.
REQ-021 The detector SHALL be a Mealy machine for pattern 1101 with four states:
- S0: in=1 goes to S1; in=0 stays in S0.
- S1: in=1 goes to S2; in=0 goes to S0.
- S2: in=1 stays in S2; in=0 goes to S3.
- S3: in=1 goes to S1 and reports a match (overlap); in=0 goes to S0.
REQ-022 match_cnt SHALL increment on each edge that consumes a matching bit, saturating at all-ones.
REQ-023 match_cnt, done_id and window SHALL hold their values until the next accept edge (match_cnt, done_id) or the next SHIFT edge (window).
REQ-024 Without the carry option, the detector SHALL be forced to S0 on every accept edge.
REQ-025 A requester deasserting valid during SHIFT SHALL have no effect on the job in progress.

Reset
REQ-026 Asserting reset at any time, including mid-SHIFT, SHALL immediately drive:
- FSM to IDLE and detector to S0;
- match_cnt=0, window=0, done=0, done_id=0, ser_bit=0, busy=0;
- last-served pointer to requester 1.
REQ-027 A job aborted by reset SHALL produce no done pulse; the word is lost and the requester must resubmit.

Configuration
REQ-028 With SEQ_DET_CARRY_EN defined, the detector state SHALL NOT reset on accept, so a pattern may straddle consecutive jobs and is counted in the later job.
REQ-029 Without SEQ_DET_CARRY_EN, REQ-024 applies and every job scans independently.

Structure
REQ-030 Package seq_det_pkg SHALL hold:
- the FSM state enum (IDLE, SHIFT, DONE);
- the detector state enum (S0..S3);
- the constant PATTERN = 4'b1101.
REQ-031 The detector SHALL be sub-module seq_det_1101 with ports clk, reset, clr, en, in, match; its state advances only when en=1.

Verification
REQ-032 Job to check match counting, window and latency:
- Stimulus: after reset, req0 sends 8'b11011011.
- Response: done 8 cycles after accept; match_cnt=2, done_id=0, window=4'b1101.
REQ-033 Simultaneous requests to check round-robin order:
- Stimulus: req0 and req1 both valid in the same cycle after reset.
- Response: req0 is granted first and req1 is granted in the IDLE cycle after that job's DONE; done_id sequence is 0, 1.
REQ-034 Repeated requester to check pointer behaviour: req1 alone sends three words back-to-back; each job is accepted in the IDLE cycle following DONE.
REQ-035 Reset mid-job:
- Stimulus: reset asserted at the 4th SHIFT cycle.
- Response: no done pulse; all outputs 0; next accept works normally.
REQ-036 Cross-job pattern with the carry option:
- Stimulus: job 8'b00000110, then job 8'b10000000.
- Response: second job match_cnt=1 with SEQ_DET_CARRY_EN, 0 without; 8'b11111111 gives 0.
